// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code set 2 key-event assembler with a first-word-fall-through event FIFO.
// Folds E0/F0 prefixes into single {brk, ext, code} events, tracks held modifiers
// and raises a level interrupt while events wait for the host.
module ps2_key_event_queue #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              rd_en,
    input  logic              irq_en,
    input  logic              ovf_clear,
    output logic [9:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [2:0]        mods,
    output logic              irq
);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    localparam int                TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               w_tmo_hit;
    logic               w_emit;
    logic [9:0]         w_event;
    logic               w_is_resp;

    logic [9:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_overflow;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    logic               r_lshift;
    logic               r_rshift;
    logic               r_ctrl;
    logic               r_alt;

    // Controller response bytes that never form key events.
    assign w_is_resp = (in_data == 8'hFA) || (in_data == 8'hAA) || (in_data == 8'hEE) ||
                       (in_data == 8'hFE) || (in_data == 8'hFC) || (in_data == 8'h00) ||
                       (in_data == 8'hFF);

    assign w_tmo_hit = (r_state != S_IDLE) && !in_valid && (r_tmo_cnt == TMO_LAST);

    // Parser state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Parser next-state: advance on each byte, fall back to IDLE on prefix timeout.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // (which would infer a latch).
        w_state_nxt = r_state;
        if (in_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (in_data == 8'hE0)      w_state_nxt = S_EXT;
                    else if (in_data == 8'hF0) w_state_nxt = S_BRK;
                end
                S_EXT: begin
                    if (in_data == 8'hF0)      w_state_nxt = S_EXT_BRK;
                    else if (in_data != 8'hE0) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (w_tmo_hit) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Parser outputs: a completed event and its {brk, ext, code} encoding.
    always_comb begin
        w_emit  = 1'b0;
        w_event = {2'b00, in_data};
        if (in_valid) begin
            case (r_state)
                S_IDLE: w_emit = !w_is_resp && (in_data != 8'hE0) && (in_data != 8'hF0);
                S_EXT: begin
                    w_emit  = (in_data != 8'hE0) && (in_data != 8'hF0);
                    w_event = {2'b01, in_data};
                end
                S_BRK: begin
                    w_emit  = 1'b1;
                    w_event = {2'b10, in_data};
                end
                default: begin
                    w_emit  = 1'b1;
                    w_event = {2'b11, in_data};
                end
            endcase
        end
    end

    // Prefix timeout counter: runs only while a prefix waits for its next byte.
    always_ff @(posedge clk) begin
        if (reset || in_valid || r_state == S_IDLE || w_tmo_hit) r_tmo_cnt <= '0;
        else                                                     r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end

    // Modifier tracking: every emitted event counts, even one the FIFO drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lshift <= 1'b0;
            r_rshift <= 1'b0;
            r_ctrl   <= 1'b0;
            r_alt    <= 1'b0;
        end else if (w_emit) begin
            if (w_event[7:0] == 8'h12 && !w_event[8]) r_lshift <= !w_event[9];
            if (w_event[7:0] == 8'h59 && !w_event[8]) r_rshift <= !w_event[9];
            if (w_event[7:0] == 8'h14)                r_ctrl   <= !w_event[9];
            if (w_event[7:0] == 8'h11)                r_alt    <= !w_event[9];
        end
    end

    assign empty  = (r_count == '0);
    assign full   = (r_count == DEPTH_C);
    assign w_pop  = rd_en && !empty;
    assign w_push = w_emit && (!full || w_pop);
    assign w_drop = w_emit && full && !w_pop;

    // FIFO storage: data only, no reset.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is deliberately not reset; pointers and count
        // define validity, and unreset storage maps onto plain RAM/registers.
        if (w_push) r_mem[r_wr_ptr] <= w_event;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (ADDR_W + 1)'(1);
            else if (!w_push && w_pop) r_count <= r_count - (ADDR_W + 1)'(1);
            if (w_drop)         r_overflow <= 1'b1;
            else if (ovf_clear) r_overflow <= 1'b0;
        end
    end

    assign rd_data  = empty ? 10'd0 : r_mem[r_rd_ptr];
    assign count    = r_count;
    assign overflow = r_overflow;
    assign mods     = {r_alt, r_ctrl, r_lshift | r_rshift};
    assign irq      = irq_en && !empty;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: parser sequences, modifiers, FIFO
// full/overflow behaviour, prefix timeout and interrupt gating.
module tb_ps2_key_event_queue;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 3;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              rd_en;
    logic              irq_en;
    logic              ovf_clear;
    logic [9:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [2:0]        mods;
    logic              irq;

    int n_vec = 0;
    int n_err = 0;

    ps2_key_event_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .rd_en     (rd_en),
        .irq_en    (irq_en),
        .ovf_clear (ovf_clear),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .mods      (mods),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        rd_en     = 1'b0;
        irq_en    = 1'b1;
        ovf_clear = 1'b0;
        do_reset();

        // Reset state
        check("rst_rd_data",  16'(rd_data),  16'h000);
        check("rst_empty",    16'(empty),    16'd1);
        check("rst_full",     16'(full),     16'd0);
        check("rst_count",    16'(count),    16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
        check("rst_mods",     16'(mods),     16'd0);
        check("rst_irq",      16'(irq),      16'd0);

        // 1: single make code, latency of one edge, pop back to empty
        in_valid = 1'b1;
        in_data  = 8'h1C;
        #1;
        check("t1_empty_cycN", 16'(empty), 16'd1);
        tick();
        in_valid = 1'b0;
        check("t1_empty_N1", 16'(empty),   16'd0);
        check("t1_rd_data",  16'(rd_data), 16'h01C);
        check("t1_count",    16'(count),   16'd1);
        check("t1_irq",      16'(irq),     16'd1);
        pop();
        check("t1_pop_empty", 16'(empty),   16'd1);
        check("t1_pop_data",  16'(rd_data), 16'h000);
        pop();
        check("t1_pop_when_empty", 16'(count), 16'd0);

        // 2: prefix combinations and dropped controller responses
        send(8'hE0); send(8'hF0); send(8'h75);
        check("t2_ext_brk_cnt", 16'(count),   16'd1);
        check("t2_ext_brk",     16'(rd_data), 16'h375);
        pop();
        send(8'hE0); send(8'h74);
        check("t2_ext_make", 16'(rd_data), 16'h174);
        pop();
        send(8'hF0); send(8'h1C);
        check("t2_brk", 16'(rd_data), 16'h21C);
        pop();
        send(8'hFA); send(8'hAA);
        check("t2_resp_dropped", 16'(empty), 16'd1);
        send(8'hE0); send(8'hE0); send(8'h6B);
        check("t2_double_e0", 16'(rd_data), 16'h16B);
        pop();

        // 3: modifier tracking
        send(8'h12);
        check("t3_lshift_make", 16'(mods), 16'b001);
        send(8'h59);
        send(8'hF0); send(8'h12);
        check("t3_rshift_held", 16'(mods), 16'b001);
        send(8'hF0); send(8'h59);
        check("t3_shift_released", 16'(mods), 16'b000);
        send(8'hE0); send(8'h14);
        check("t3_ext_ctrl", 16'(mods), 16'b010);
        send(8'h11);
        check("t3_alt", 16'(mods), 16'b110);
        check("t3_count", 16'(count), 16'd6);
        do_reset();
        check("t3_reset_mods", 16'(mods), 16'b000);

        // 4: fill, overflow, push+pop while full, ovf_clear priority, drain with wrap
        for (int i = 1; i <= DEPTH; i++) send(8'(i));
        check("t4_full",       16'(full),     16'd1);
        check("t4_count8",     16'(count),    16'd8);
        check("t4_no_ovf_yet", 16'(overflow), 16'd0);
        send(8'h09);
        check("t4_ovf_set",  16'(overflow), 16'd1);
        check("t4_count_9",  16'(count),    16'd8);
        check("t4_head_9",   16'(rd_data),  16'h001);
        rd_en = 1'b1;
        send(8'h0A);
        rd_en = 1'b0;
        check("t4_pushpop_count", 16'(count),   16'd8);
        check("t4_pushpop_head",  16'(rd_data), 16'h002);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("t4_ovf_clear", 16'(overflow), 16'd0);
        ovf_clear = 1'b1;
        send(8'h0B);
        ovf_clear = 1'b0;
        check("t4_set_beats_clear", 16'(overflow), 16'd1);
        irq_en = 1'b0;
        #1;
        check("t6_irq_disabled", 16'(irq), 16'd0);
        irq_en = 1'b1;
        #1;
        for (int i = 2; i <= 9; i++) begin
            check("t6_irq_pending", 16'(irq), 16'd1);
            check("t4_drain_data",  16'(rd_data), (i == 9) ? 16'h00A : 16'(i));
            pop();
        end
        check("t6_irq_drained", 16'(irq),   16'd0);
        check("t4_drained",     16'(empty), 16'd1);

        // 5: prefix timeout boundary and reset dropping a partial prefix
        send(8'hE0);
        repeat (TIMEOUT - 1) tick();
        send(8'h1C);
        check("t5_just_in_time", 16'(rd_data), 16'h11C);
        pop();
        send(8'hE0);
        repeat (TIMEOUT) tick();
        send(8'h1C);
        check("t5_timed_out", 16'(rd_data), 16'h01C);
        pop();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("t5_reset_prefix", 16'(rd_data), 16'h01C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
